// File: rtl/bitcell_ctrl.sv
// bitcell_ctrl: sequences read/write strobes onto a ROWS x DATA_W bitcell array.
// Optional write-verify readback is enabled by defining BITCELL_CTRL_WRITE_VERIFY_EN.
// All cell_* outputs are flops loaded from the next-state decode.
module bitcell_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [DATA_W-1:0]    cell_in,
  output logic [2**ADDR_W-1:0] cell_sel,
  output logic                 cell_r_w,
  input  logic [DATA_W-1:0]    cell_out,
  output logic                 wr_err
);

  localparam int unsigned ROWS = 2**ADDR_W;

`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SEL, R_SAMPLE, RESP, V_SEL, V_SAMPLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SEL, R_SAMPLE, RESP
  } state_t;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_cell_in;
  logic [ROWS-1:0]     r_cell_sel;
  logic                r_cell_r_w;

  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [ROWS-1:0]     w_row_sel;
  logic [DATA_W-1:0]   w_cell_in_nxt;
  logic [ROWS-1:0]     w_cell_sel_nxt;
  logic                w_cell_r_w_nxt;

  // Acceptance only happens in IDLE; the target of the next cycle comes from the request then.
  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_addr    = w_accept ? req_addr  : r_addr;
  assign w_data    = w_accept ? req_wdata : r_data;
  assign w_row_sel = ROWS'(1) << w_addr;

  // Next-state logic and next-cycle cell drive decoded from the upcoming state.
  always_comb begin
    w_next_state   = r_state;
    w_cell_in_nxt  = '0;
    w_cell_sel_nxt = '0;
    w_cell_r_w_nxt = 1'b0;

    case (r_state)
      IDLE:     if (req_valid) w_next_state = req_we ? W_SETUP : R_SEL;
      W_SETUP:  w_next_state = W_STROBE;
      W_STROBE: w_next_state = W_HOLD;
`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
      W_HOLD:   w_next_state = V_SEL;
      V_SEL:    w_next_state = V_SAMPLE;
      V_SAMPLE: w_next_state = IDLE;
`else
      W_HOLD:   w_next_state = IDLE;
`endif
      R_SEL:    w_next_state = R_SAMPLE;
      R_SAMPLE: w_next_state = RESP;
      RESP:     if (rsp_ready) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase

    case (w_next_state)
      W_SETUP, W_HOLD: begin
        w_cell_r_w_nxt = 1'b1;
        w_cell_in_nxt  = w_data;
      end
      W_STROBE: begin
        w_cell_r_w_nxt = 1'b1;
        w_cell_in_nxt  = w_data;
        w_cell_sel_nxt = w_row_sel;
      end
`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
      R_SEL, R_SAMPLE, V_SEL, V_SAMPLE: w_cell_sel_nxt = w_row_sel;
`else
      R_SEL, R_SAMPLE: w_cell_sel_nxt = w_row_sel;
`endif
      default: ;
    endcase
  end

  // State, handshake and cell-drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cell_in   <= '0;
      r_cell_sel  <= '0;
      r_cell_r_w  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == IDLE);
      r_rsp_valid <= (w_next_state == RESP);
      r_cell_in   <= w_cell_in_nxt;
      r_cell_sel  <= w_cell_sel_nxt;
      r_cell_r_w  <= w_cell_r_w_nxt;
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_wdata;
      end
      if (r_state == R_SAMPLE) r_rdata <= cell_out;
    end
  end

`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
  logic r_wr_err;

  // Sticky flag: readback at the end of V_SAMPLE must equal the written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if ((r_state == V_SAMPLE) && (cell_out != r_data)) begin
      r_wr_err <= 1'b1;
    end
  end

  assign wr_err = r_wr_err;
`else
  assign wr_err = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign cell_in   = r_cell_in;
  assign cell_sel  = r_cell_sel;
  assign cell_r_w  = r_cell_r_w;

endmodule

// File: doc/bitcell_ctrl.md
BITCELL_CTRL -- requirements
Module: bitcell_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning the row address width (ROWS = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the number of bitcells per row.
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  meaning a request is presented.
REQ-006 SHALL have port req_ready  output  1  meaning the controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  meaning the request type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  meaning the target row.
REQ-009 SHALL have port req_wdata  input  DATA_W  meaning the write data.
REQ-010 SHALL have port rsp_valid  output  1  meaning read data is available.
REQ-011 SHALL have port rsp_ready  input  1  meaning the consumer takes the read data.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  meaning the captured read data.
REQ-013 SHALL have port cell_in  output  DATA_W  meaning the value driven to the in pin of every bitcell in a column.
REQ-014 SHALL have port cell_sel  output  ROWS  meaning the one-hot row select driven to the sel pins of that row.
REQ-015 SHALL have port cell_r_w  output  1  meaning the value driven to all r_w pins: 1 = write, 0 = read.
REQ-016 SHALL have port cell_out  input  DATA_W  meaning the column-wise OR of the bitcell out pins.
REQ-017 SHALL have port wr_err  output  1  meaning a sticky write-verify mismatch flag.

Function
REQ-018 SHALL implement the FSM states IDLE, W_SETUP, W_STROBE, W_HOLD, R_SEL, R_SAMPLE and RESP, plus V_SEL and V_SAMPLE when REQ-034 applies.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready at a clock edge, and req_addr, req_we and req_wdata are registered at acceptance.
REQ-020 SHALL transition on a write as IDLE -> W_SETUP -> W_STROBE -> W_HOLD -> IDLE, one cycle each, so req_ready returns 4 cycles after acceptance.
REQ-021 SHALL, in W_SETUP, drive cell_r_w = 1, cell_in = the registered data and cell_sel = 0, so that data settles before the select is asserted.
REQ-022 SHALL, in W_STROBE, assert cell_sel[addr] for exactly one cycle, with cell_r_w = 1 and cell_in held.
REQ-023 SHALL, in W_HOLD, drive cell_sel = 0 while keeping cell_r_w = 1 and cell_in stable.
REQ-024 SHALL transition on a read as IDLE -> R_SEL -> R_SAMPLE -> RESP.
REQ-025 SHALL, in R_SEL and R_SAMPLE, drive cell_r_w = 0 and cell_sel[addr] = 1.
REQ-026 SHALL capture cell_out into rsp_rdata at the end of R_SAMPLE.
REQ-027 SHALL, in RESP, drive rsp_valid = 1 and hold rsp_rdata stable until rsp_ready = 1.
REQ-028 SHALL, when rsp_valid && rsp_ready at a clock edge in RESP, return to IDLE, giving rsp_valid high 3 cycles after acceptance at the earliest.
REQ-029 SHALL, in IDLE, drive cell_sel = 0, cell_r_w = 0 and cell_in = 0.
REQ-030 SHALL change cell_r_w only in cycles where cell_sel = 0, and never assert more than one cell_sel bit.
REQ-031 SHALL ignore req_valid outside IDLE; a write issues no response.
REQ-032 SHALL register all cell_* outputs, with no combinational path from req_* to cell_*.

Reset
REQ-033 SHALL, on rst_n = 0 at any time including mid-operation, immediately force state = IDLE, cell_sel = 0, cell_r_w = 0, cell_in = 0, rsp_valid = 0, rsp_rdata = 0 and wr_err = 0, with req_ready = 1 after release; bitcell contents are not cleared.

Configuration
REQ-034 SHALL, with BITCELL_CTRL_WRITE_VERIFY_EN defined, route W_HOLD -> V_SEL -> V_SAMPLE -> IDLE, apply read drive in those states and compare cell_out against the written data at the end of V_SAMPLE, setting wr_err on mismatch (sticky until reset); write latency becomes 6 cycles.
REQ-035 SHALL, without BITCELL_CTRL_WRITE_VERIFY_EN, omit the V_* states and tie wr_err to 0.

Verification
REQ-036 SHALL cover: write addr 3, data 0xA5 -> cell_sel = 0x08 for exactly one cycle with cell_r_w = 1 and cell_in = 0xA5 one cycle before and after, req_ready high again at acceptance+4.
REQ-037 SHALL cover: write 0x3C to addr 5, then read addr 5 -> rsp_valid at acceptance+3 with rsp_rdata = 0x3C, and no other row ever selected.
REQ-038 SHALL cover: read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout, return to IDLE one cycle after rsp_ready = 1.
REQ-039 SHALL cover: rst_n asserted during W_STROBE of a write of 0xFF to addr 1 -> cell_sel = 0 and cell_r_w = 0 immediately; a subsequent read of addr 1 returns either the old value or 0xFF, never X.
REQ-040 SHALL cover, with BITCELL_CTRL_WRITE_VERIFY_EN: cell_out bit 0 forced low during V_SAMPLE on a write of 0x01 -> wr_err = 1 and staying 1 until reset; without the macro, wr_err = 0 and write latency = 4.
